// File: rtl/divider.sv
// Sequential signed integer divider (restoring, one quotient bit per clock).
//
// Produces the truncated (C-style) quotient and remainder of two WIDTH-bit
// two's-complement operands. Magnitudes are divided and signs are applied
// in a final fix-up cycle. Divide-by-zero skips the iterations entirely.
//
// Ports:
//   clock        rising-edge system clock
//   reset_n      asynchronous active-low reset
//   start        operation request, sampled only while busy is low
//   dividend     signed dividend, sampled with an accepted start
//   divisor      signed divisor, sampled with an accepted start
//   busy         high from the accepting edge until results are registered
//   done         one-cycle pulse when quotient/remainder/div_by_zero update
//   quotient     signed quotient, held until the next done
//   remainder    signed remainder (sign follows the dividend), held
//   div_by_zero  set with done when the divisor was zero; cleared on the
//                next accepted start
module divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    logic [WIDTH:0]   d_mag;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] q_reg;
    logic             neg_q;
    logic             neg_r;
    logic             zero_div;

    logic             accept;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        accept       = (state == IDLE) && start;
        // The most-negative value maps onto itself, which is the correct
        // unsigned magnitude when read as WIDTH-bit unsigned.
        dividend_abs = dividend[WIDTH-1] ? -dividend : dividend;
        divisor_abs  = divisor[WIDTH-1]  ? -divisor  : divisor;
        // q_reg doubles as the dividend shift register: its MSB feeds the
        // partial remainder while quotient bits enter at the LSB.
        shifted      = {part_rem, q_reg[WIDTH-1]};
        // shifted < 2*|divisor|, so the difference always lies within
        // +/-2^WIDTH and bit WIDTH is a valid sign bit.
        trial        = shifted - d_mag;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? FIX : RUN;
                end
            end
            RUN: begin
                if (count == CW'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count       <= '0;
            d_mag       <= '0;
            part_rem    <= '0;
            q_reg       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_div    <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        d_mag       <= {1'b0, divisor_abs};
                        q_reg       <= dividend_abs;
                        part_rem    <= '0;
                        count       <= CW'(WIDTH);
                        neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r       <= dividend[WIDTH-1];
                        zero_div    <= (divisor == '0);
                        div_by_zero <= 1'b0;
                    end
                end
                RUN: begin
                    if (trial[WIDTH]) begin
                        part_rem <= shifted[WIDTH-1:0];
                        q_reg    <= {q_reg[WIDTH-2:0], 1'b0};
                    end else begin
                        part_rem <= trial[WIDTH-1:0];
                        q_reg    <= {q_reg[WIDTH-2:0], 1'b1};
                    end
                    count <= count - CW'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    if (zero_div) begin
                        // No iterations ran, so q_reg still holds |dividend|;
                        // re-applying the sign restores the dividend exactly.
                        quotient    <= '1;
                        remainder   <= neg_r ? -q_reg : q_reg;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= neg_q ? -q_reg : q_reg;
                        remainder   <= neg_r ? -part_rem : part_rem;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the sequential signed divider.
// A reference model computes results with host integer division and tracks
// when done/busy must appear; a negedge process compares every cycle.
module tb_divider;

    localparam int unsigned W = 32;

    logic         clock   = 1'b0;
    logic         reset_n = 1'b0;
    logic         start   = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor  = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    divider #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: truncating signed division in 64-bit arithmetic.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint la, lb, lq, lr;
        if (b == '0) begin
            q = '1;
            r = a;
        end else begin
            la = $signed(a);
            lb = $signed(b);
            lq = la / lb;
            lr = la % lb;
            q  = lq[W-1:0];
            r  = lr[W-1:0];
        end
    endfunction

    // ---------------- reference model (transaction level) ----------------
    int           rem_cycles = 0;
    logic         exp_done   = 1'b0;
    logic         exp_dz     = 1'b0;
    logic [W-1:0] exp_q      = '0;
    logic [W-1:0] exp_r      = '0;
    logic         pend_dz    = 1'b0;
    logic [W-1:0] pend_q     = '0;
    logic [W-1:0] pend_r     = '0;
    logic [W-1:0] pend_a     = '0;
    logic [W-1:0] pend_b     = '0;
    logic [W-1:0] op_a       = '0;
    logic [W-1:0] op_b       = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_cycles = 0;
            exp_done   = 1'b0;
            exp_dz     = 1'b0;
            exp_q      = '0;
            exp_r      = '0;
        end else begin
            exp_done = 1'b0;
            if (rem_cycles > 0) begin
                rem_cycles--;
                if (rem_cycles == 0) begin
                    exp_done = 1'b1;
                    exp_q    = pend_q;
                    exp_r    = pend_r;
                    exp_dz   = pend_dz;
                    op_a     = pend_a;
                    op_b     = pend_b;
                end
            end else if (start) begin
                ref_div(dividend, divisor, pend_q, pend_r);
                pend_dz    = (divisor == '0);
                pend_a     = dividend;
                pend_b     = divisor;
                exp_dz     = 1'b0;
                rem_cycles = (divisor == '0) ? 1 : W + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [W-1:0] recon;
    longint       abs_r, abs_b;

    always @(negedge clock) begin
        check("busy", busy, rem_cycles > 0);
        check("done", done, exp_done);
        check("quotient", quotient, exp_q);
        check("remainder", remainder, exp_r);
        check("div_by_zero", div_by_zero, exp_dz);
        if (exp_done && op_b != '0) begin
            recon = quotient * op_b + remainder;
            check("invariant", recon, op_a);
            abs_r = $signed(remainder);
            abs_b = $signed(op_b);
            if (abs_r < 0) abs_r = -abs_r;
            if (abs_b < 0) abs_b = -abs_b;
            check("rem_mag", abs_r < abs_b, 1);
            check("rem_sign", (remainder == '0) || (remainder[W-1] == op_a[W-1]), 1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Called #1 after the accepting edge; returns edges until done and the
    // number of sampled busy cycles (including the one right after accept).
    task automatic wait_done(input bit junk, output int n, output int bc);
        n  = 0;
        bc = 0;
        while (!done && n < 100) begin
            if (busy) bc++;
            if (junk) begin
                start    = ($urandom % 4 == 0);
                dividend = $urandom;
                divisor  = $urandom;
            end
            @(posedge clock);
            #1;
            n++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input string name);
        int n, bc;
        @(posedge clock);
        #1;
        start_op(a, b);
        wait_done(1'b0, n, bc);
        check({name, "_latency"}, n, edz ? 1 : W + 1);
        check({name, "_busy_cycles"}, bc, edz ? 1 : W + 1);
        check({name, "_q"}, quotient, eq);
        check({name, "_r"}, remainder, er);
        check({name, "_dz"}, div_by_zero, edz);
        check({name, "_busy_at_done"}, busy, 0);
        @(posedge clock);
        #1;
        check({name, "_done_one_cycle"}, done, 0);
        check({name, "_q_held"}, quotient, eq);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 8)
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'd1;
            4:       return W'($urandom_range(0, 40));
            5:       return -W'($urandom_range(1, 40));
            default: return $urandom;
        endcase
    endfunction

    // Hand-computed cases: a, b, quotient, remainder, div_by_zero.
    logic [W-1:0] t_a [10] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C, 32'h8000_0000,
                              32'h8000_0000, 32'd7, 32'd0, 32'd5, 32'd9};
    logic [W-1:0] t_b [10] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                              32'd1, 32'd100, 32'd5, 32'd0, 32'd3};
    logic [W-1:0] t_q [10] = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14, 32'h8000_0000,
                              32'h8000_0000, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd3};
    logic [W-1:0] t_r [10] = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFE, 32'd0,
                              32'd0, 32'd7, 32'd0, 32'd5, 32'd0};
    logic         t_z [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected summary before time limit");
        $fatal(1, "time limit reached");
    end

    initial begin
        logic [W-1:0] mq, mr;
        int           n, bc;
        bit           abort;

        abort = 1'b0;

        // Pin the reference model to hand-computed values.
        for (int i = 0; i < 10; i++) begin
            ref_div(t_a[i], t_b[i], mq, mr);
            check("model_q", mq, t_q[i]);
            check("model_r", mr, t_r[i]);
        end

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dz", div_by_zero, 0);
        @(negedge clock);
        #2;
        reset_n = 1'b1;

        // Directed table (includes 5/0 followed by 9/3).
        for (int i = 0; i < 10; i++) begin
            do_op(t_a[i], t_b[i], t_q[i], t_r[i], t_z[i], $sformatf("dir%0d", i));
        end

        // start while busy is ignored.
        @(posedge clock);
        #1;
        start_op(32'd100, 32'd7);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        dividend = 32'd1;
        divisor  = 32'd1;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(1'b0, n, bc);
        check("ignore_latency", n, W + 1 - 10);
        check("ignore_q", quotient, 14);
        check("ignore_r", remainder, 2);

        // start in the done cycle is accepted; old results hold meanwhile.
        start_op(32'd20, 32'd6);
        check("chain_done_low", done, 0);
        check("chain_q_hold", quotient, 14);
        check("chain_busy", busy, 1);
        wait_done(1'b0, n, bc);
        check("chain_latency", n, W + 1);
        check("chain_q", quotient, 3);
        check("chain_r", remainder, 2);

        // Asynchronous reset mid-operation.
        @(posedge clock);
        #1;
        start_op(32'd100, 32'd7);
        repeat (14) begin
            @(posedge clock);
            #1;
        end
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_q", quotient, 0);
        check("arst_r", remainder, 0);
        check("arst_dz", div_by_zero, 0);
        repeat (3) @(negedge clock);
        #2;
        reset_n = 1'b1;
        repeat (40) begin
            @(posedge clock);
            #1;
            check("arst_no_done", done, 0);
        end
        do_op(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, "after_rst");

        // Randomised operations with ignored start pulses and back-to-back starts.
        for (int i = 0; i < 1200 && !abort; i++) begin
            logic [W-1:0] a, b;
            a = pick();
            b = pick();
            if ($urandom % 16 == 0) b = '0;
            start_op(a, b);
            wait_done(1'b1, n, bc);
            if (!done) abort = 1'b1;
            check("rand_latency", n, (b == '0) ? 1 : W + 1);
            if ($urandom % 2 == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clock);
                    #1;
                end
            end
        end

        repeat (3) @(posedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
